// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: queued 8N1 UART transmitter.
//
// Bytes written by the CPU land in a small FIFO. A four-state FSM
// (IDLE/START/DATA/STOP) pops them one at a time and shifts them out LSB
// first. Each serial bit lasts exactly CLKS_PER_BIT clk cycles. When another
// byte is already queued at the end of a stop bit, frames run back-to-back
// with no idle gap.
//
// Ports:
//   clk      in   CPU clock
//   reset    in   asynchronous reset, active low (0 = in reset)
//   tx_data  in   [7:0] byte to enqueue
//   tx_wr    in   write strobe; accepted on a rising edge when tx_full=0
//   tx_full  out  FIFO holds FIFO_DEPTH bytes
//   tx_busy  out  FIFO non-empty or a frame in progress
//   UART_TX  out  serial line, idle high, driven straight from a flop
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 1302,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic       tx_busy,
    output logic       UART_TX
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        busy_q;
    logic        full_q;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] wr_ptr_d, rd_ptr_d, count_d;
    logic [7:0]  mem_q [FIFO_DEPTH];

    logic empty;
    logic wr_en;
    logic pop;
    logic baud_last;
    logic active_d;

    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        // full_q reflects the count before this edge, so a write when full is
        // rejected even if a pop happens on the same edge.
        wr_en     = tx_wr & ~full_q;
        baud_last = (baud_q == BAUD_LAST);
        // The FSM pops either from IDLE or at the very last cycle of a stop bit.
        pop       = ~empty & ((state_q == IDLE) | ((state_q == STOP) & baud_last));
        wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, wr_en};
        rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, pop};
        count_d   = wr_ptr_d - rd_ptr_d;
        // FSM will be outside IDLE after this edge.
        active_d  = pop | ((state_q != IDLE) & ~((state_q == STOP) & baud_last));
    end

    // Storage is not reset; only the pointers define what is valid. A write
    // and a pop never touch the same slot because a pop needs a non-empty FIFO.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            full_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= (count_d == DEPTH_C);
            busy_q   <= active_d | (count_d != '0);

            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q[AW-1:0]];
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (pop) begin
                            // Back-to-back frame: start bit begins right away.
                            shift_q <= mem_q[rd_ptr_q[AW-1:0]];
                            tx_q    <= 1'b0;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    baud_q  <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign UART_TX = tx_q;
    assign tx_busy = busy_q;
    assign tx_full = full_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// A frame is 40 cycles. Inputs are driven and outputs sampled on the falling
// clock edge.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_full;
    logic       tx_busy;
    logic       UART_TX;

    int tests = 0;
    int fails = 0;

    // Write schedule (cycle index, data) and expected frame bytes in order.
    int         wc_a [8];
    logic [7:0] wd_a [8];
    logic [7:0] fb_a [8];

    uart_tx_fifo #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .tx_data(tx_data),
        .tx_wr  (tx_wr),
        .tx_full(tx_full),
        .tx_busy(tx_busy),
        .UART_TX(UART_TX)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int c, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, obs, exp);
        end
    endtask

    // Cycle c means "just after rising edge E+c", where E is the edge that
    // takes the first write. The first start bit appears after edge E+1, so
    // line bit s = c-1 belongs to frame s/40, frame bit (s%40)/4.
    task automatic run_case(input string tag, input int nw, input int nf,
                            input int flo, input int fhi);
        int         s;
        logic       w;
        logic       exp_tx;
        logic [7:0] d;
        logic [9:0] fr;
        for (int c = 0; c <= 40 * nf + 1; c++) begin
            w = 1'b0;
            d = 8'h00;
            for (int k = 0; k < nw; k++) begin
                if (wc_a[k] == c) begin
                    w = 1'b1;
                    d = wd_a[k];
                end
            end
            tx_wr   = w;
            tx_data = d;
            @(negedge clk);
            s      = c - 1;
            exp_tx = 1'b1;
            if (s >= 0 && s < 40 * nf) begin
                fr     = {1'b1, fb_a[s / 40], 1'b0};
                exp_tx = fr[(s % 40) / 4];
            end
            chk({tag, "_tx"},   c, UART_TX, exp_tx);
            chk({tag, "_busy"}, c, tx_busy, (c <= 40 * nf));
            chk({tag, "_full"}, c, tx_full, (c >= flo && c <= fhi));
        end
        tx_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] fr;

        // Reset held: line idle, flags clear.
        repeat (3) @(negedge clk);
        chk("rst_tx",   0, UART_TX, 1'b1);
        chk("rst_busy", 0, tx_busy, 1'b0);
        chk("rst_full", 0, tx_full, 1'b0);
        reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_tx",   c, UART_TX, 1'b1);
            chk("idle_busy", c, tx_busy, 1'b0);
            chk("idle_full", c, tx_full, 1'b0);
        end

        // Single byte 0xA5: bits 0,1,0,1,0,0,1,0,1,1; busy drops at cycle 41.
        wc_a = '{0, -1, -1, -1, -1, -1, -1, -1};
        wd_a = '{8'hA5, 0, 0, 0, 0, 0, 0, 0};
        fb_a = '{8'hA5, 0, 0, 0, 0, 0, 0, 0};
        run_case("a5", 1, 1, 1, 0);
        repeat (3) @(negedge clk);

        // Four consecutive writes: never full, four back-to-back frames.
        wc_a = '{0, 1, 2, 3, -1, -1, -1, -1};
        wd_a = '{8'h00, 8'hFF, 8'h55, 8'h0F, 0, 0, 0, 0};
        fb_a = '{8'h00, 8'hFF, 8'h55, 8'h0F, 0, 0, 0, 0};
        run_case("four", 4, 4, 1, 0);
        repeat (3) @(negedge clk);

        // Six consecutive writes: count reaches 4 after cycle 4, the sixth
        // write is dropped, full clears when frame 2 is popped at cycle 41.
        wc_a = '{0, 1, 2, 3, 4, 5, -1, -1};
        wd_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 0, 0};
        fb_a = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 0, 0, 0};
        run_case("six", 6, 5, 4, 40);
        repeat (3) @(negedge clk);

        // Third byte written on the exact edge STOP pops the second byte.
        wc_a = '{0, 1, 41, -1, -1, -1, -1, -1};
        wd_a = '{8'h81, 8'h7E, 8'hC3, 0, 0, 0, 0, 0};
        fb_a = '{8'h81, 8'h7E, 8'hC3, 0, 0, 0, 0, 0};
        run_case("popwr", 3, 3, 1, 0);
        repeat (3) @(negedge clk);

        // 0x3C with two more queued; reset asserted during data bit 3.
        fr = {1'b1, 8'h3C, 1'b0};
        for (int c = 0; c <= 18; c++) begin
            tx_wr   = (c < 3);
            tx_data = (c == 0) ? 8'h3C : (c == 1) ? 8'h12 : 8'h34;
            @(negedge clk);
            if (c >= 1) chk("rstmid_tx", c, UART_TX, fr[(c - 1) / 4]);
        end
        tx_wr = 1'b0;
        chk("rstmid_busy_pre", 18, tx_busy, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("rstmid_async_tx",   0, UART_TX, 1'b1);
        chk("rstmid_async_busy", 0, tx_busy, 1'b0);
        chk("rstmid_async_full", 0, tx_full, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            chk("post_tx",   c, UART_TX, 1'b1);
            chk("post_busy", c, tx_busy, 1'b0);
            chk("post_full", c, tx_full, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
